mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port Op, input, 11: opcode field instr[31:21] from the instruction register; stable from DECODE onward.
REQ-005 SHALL have port Zero, input, 1: ALU zero flag.
REQ-006 SHALL have port mem_ready, input, 1: memory completes the current access this cycle.
REQ-007 SHALL have outputs IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSrc, ALUSrcA, RegWrite, MemtoReg, Reg2Loc, each 1 bit: datapath controls.
REQ-008 SHALL have outputs ALUSrcB, 2 bits (00 reg, 01 const 4, 10 sign-ext D-imm, 11 sign-ext branch offset <<2), and ALUOp, 2 bits (00 add, 01 pass-B/zero test, 10 funct).
REQ-009 SHALL have outputs illegal (1 bit, one-cycle pulse), state_o (4 bits, current state) and instr_count (CNT_W bits).

Function
REQ-010 SHALL be a Moore FSM; every control output is 0 unless listed for the current state.
REQ-011 SHALL use states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8.
REQ-012 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00; IRWrite=PCWrite=mem_ready; stays until mem_ready=1, then DECODE.
REQ-013 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; next LDUR/STUR->MEMADR, R-type->EXEC, CBZ->BRANCH, other->FETCH with illegal=1 that cycle.
REQ-014 Opcode classes: LDUR 11'b11111000010, STUR 11'b11111000000, CBZ Op[10:3]=8'b10110100, R-type ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
REQ-015 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next MEMRD for LDUR, MEMWR for STUR.
REQ-016 MEMRD: IorD=1, MemRead=1; holds until mem_ready, then MEMWB.
REQ-017 MEMWB: RegWrite=1, MemtoReg=1; next FETCH.
REQ-018 MEMWR: IorD=1, MemWrite=1; holds until mem_ready, then FETCH.
REQ-019 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next ALUWB. ALUWB: RegWrite=1, MemtoReg=0; next FETCH.
REQ-020 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=1, PCWrite=Zero; next FETCH.
REQ-021 Reg2Loc SHALL be 1 in every non-FETCH state when Op is STUR or CBZ, else 0.
REQ-022 instr_count SHALL increment by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB or BRANCH; not on illegal; wraps modulo 2^CNT_W.
REQ-023 MemRead/MemWrite SHALL stay asserted and IorD stable for every wait cycle until mem_ready.
REQ-024 mem_ready SHALL be ignored in states other than FETCH, MEMRD, MEMWR.
REQ-025 Latency SHALL be (cycles excluding memory waits): LDUR 5, STUR 4, R-type 4, CBZ 3, illegal 2.

Reset
REQ-026 reset=1 at a clock edge SHALL force FETCH, instr_count=0, illegal=0, from any state including mid-wait.
REQ-027 While reset=1, PCWrite, IRWrite, RegWrite, MemWrite SHALL be 0 regardless of mem_ready.
REQ-028 First cycle after reset release SHALL be a normal FETCH.

Structure
REQ-029 Package mc_pkg SHALL hold the state enum, opcode constants, ALUSrcB and ALUOp encodings.
REQ-030 Sub-module op_class SHALL combinationally map Op to {is_ldur, is_stur, is_cbz, is_rtype}.

Verification
REQ-031 LDUR (7C2), mem_ready=1 always -> states 0,1,2,3,4,0; RegWrite=MemtoReg=1 in MEMWB; instr_count 0->1.
REQ-032 STUR (7C0), mem_ready low 3 cycles in MEMWR -> MemWrite=1, IorD=1 for 4 cycles, Reg2Loc=1, no RegWrite.
REQ-033 CBZ (5A0) with Zero=1 then Zero=0 -> BRANCH PCWrite=1,PCSrc=1 then PCWrite=0; count +1 each.
REQ-034 ADD/SUB/AND/ORR back-to-back -> each 4 cycles, ALUOp=10 in EXEC, count 0->4.
REQ-035 Op=11'h000 -> DECODE illegal=1 one cycle, return FETCH, count unchanged.
REQ-036 reset asserted in MEMRD wait -> next cycle state_o=0, count=0, no RegWrite issued.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle LEGv8 controller: states, opcodes and
// datapath mux/ALU select values.
package mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_ALUWB  = 4'd7,
        ST_BRANCH = 4'd8
    } state_t;

    localparam int unsigned OP_W = 11;

    localparam logic [OP_W-1:0] OP_LDUR   = 11'b11111000010;
    localparam logic [OP_W-1:0] OP_STUR   = 11'b11111000000;
    localparam logic [7:0]      OP_CBZ_HI = 8'b10110100;
    localparam logic [OP_W-1:0] OP_ADD    = 11'b10001011000;
    localparam logic [OP_W-1:0] OP_SUB    = 11'b11001011000;
    localparam logic [OP_W-1:0] OP_AND    = 11'b10001010000;
    localparam logic [OP_W-1:0] OP_ORR    = 11'b10101010000;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BR   = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/op_class.sv
// Combinational opcode classifier: sorts the 11-bit opcode into the
// instruction classes the controller sequences differently.
module op_class
    import mc_pkg::*;
(
    input  logic [OP_W-1:0] Op,
    output logic            is_ldur,
    output logic            is_stur,
    output logic            is_cbz,
    output logic            is_rtype
);

    assign is_ldur  = (Op == OP_LDUR);
    assign is_stur  = (Op == OP_STUR);
    assign is_cbz   = (Op[10:3] == OP_CBZ_HI);
    assign is_rtype = (Op == OP_ADD) || (Op == OP_SUB) ||
                      (Op == OP_AND) || (Op == OP_ORR);

endmodule

// File: rtl/mc_controller.sv
// Multicycle LEGv8 control FSM: Moore decode of datapath controls from the
// current state plus a retired-instruction counter.
module mc_controller
    import mc_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [10:0]      Op,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic             ALUSrcA,
    output logic             RegWrite,
    output logic             MemtoReg,
    output logic             Reg2Loc,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             illegal,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] instr_count
);

    state_t state, next_state;
    logic   is_ldur, is_stur, is_cbz, is_rtype;
    logic   count_inc;

    op_class u_op_class (
        .Op       (Op),
        .is_ldur  (is_ldur),
        .is_stur  (is_stur),
        .is_cbz   (is_cbz),
        .is_rtype (is_rtype)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_FETCH;
            instr_count <= '0;
        end else begin
            state <= next_state;
            if (count_inc) instr_count <= instr_count + CNT_W'(1);
        end
    end

    always_comb begin
        next_state = state;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        PCSrc      = 1'b0;
        ALUSrcA    = 1'b0;
        RegWrite   = 1'b0;
        MemtoReg   = 1'b0;
        ALUSrcB    = SRCB_REG;
        ALUOp      = ALUOP_ADD;
        illegal    = 1'b0;
        count_inc  = 1'b0;

        case (state)
            ST_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) next_state = ST_DECODE;
            end
            ST_DECODE: begin
                ALUSrcB = SRCB_BR;
                if (is_ldur || is_stur) next_state = ST_MEMADR;
                else if (is_rtype)      next_state = ST_EXEC;
                else if (is_cbz)        next_state = ST_BRANCH;
                else begin
                    next_state = ST_FETCH;
                    illegal    = 1'b1;
                end
            end
            ST_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                next_state = is_ldur ? ST_MEMRD : ST_MEMWR;
            end
            ST_MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (mem_ready) next_state = ST_MEMWB;
            end
            ST_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                next_state = ST_FETCH;
                count_inc  = 1'b1;
            end
            ST_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    next_state = ST_FETCH;
                    count_inc  = 1'b1;
                end
            end
            ST_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_REG;
                ALUOp      = ALUOP_FUNCT;
                next_state = ST_ALUWB;
            end
            ST_ALUWB: begin
                RegWrite   = 1'b1;
                next_state = ST_FETCH;
                count_inc  = 1'b1;
            end
            ST_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_REG;
                ALUOp      = ALUOP_PASSB;
                PCSrc      = 1'b1;
                PCWrite    = Zero;
                next_state = ST_FETCH;
                count_inc  = 1'b1;
            end
            default: next_state = ST_FETCH;
        endcase

        // Architectural state writes must never escape while reset is held
        if (reset) begin
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            illegal  = 1'b0;
        end
    end

    assign Reg2Loc = (state != ST_FETCH) && (is_stur || is_cbz);
    assign state_o = state;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: each driven cycle pushes its expected
// state/controls/count, a negedge monitor pops and compares.
module tb_mc_controller;

    localparam int unsigned CNT_W = 32;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4;
    localparam int S_MEMWR = 5, S_EXEC = 6, S_ALUWB = 7, S_BRANCH = 8;

    localparam logic [10:0] LDUR = 11'h7C2, STUR = 11'h7C0, CBZ = 11'h5A0;
    localparam logic [10:0] ADD = 11'h458, SUB = 11'h658, AND_ = 11'h450, ORR = 11'h550;

    logic clk = 1'b0;
    logic reset, Zero, mem_ready;
    logic [10:0] Op;
    logic IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSrc, ALUSrcA, RegWrite, MemtoReg, Reg2Loc;
    logic [1:0] ALUSrcB, ALUOp;
    logic illegal;
    logic [3:0] state_o;
    logic [CNT_W-1:0] instr_count;

    mc_controller #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .MemtoReg(MemtoReg), .Reg2Loc(Reg2Loc), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .illegal(illegal), .state_o(state_o), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]       st;
        logic [13:0]      ctrl;
        logic             ill;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] exp_count = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic legal(input logic [10:0] op);
        logic [7:0] hi;
        hi = op[10:3];
        return (op == LDUR) || (op == STUR) || (hi == 8'hB4) ||
               (op == ADD) || (op == SUB) || (op == AND_) || (op == ORR);
    endfunction

    // Expected controls in port order {IorD,MemRead,MemWrite,IRWrite,PCWrite,
    // PCSrc,ALUSrcA,RegWrite,MemtoReg,Reg2Loc,ALUSrcB,ALUOp}
    function automatic logic [13:0] exp_ctrl(input int s, input logic [10:0] op,
                                             input logic z, input logic mr, input logic rst);
        logic iord, mrd, mwr, irw, pcw, pcs, sa, rw, m2r, r2l;
        logic [1:0] sb_sel, aop;
        logic [7:0] hi;
        {iord, mrd, mwr, irw, pcw, pcs, sa, rw, m2r} = '0;
        sb_sel = 2'b00;
        aop    = 2'b00;
        hi     = op[10:3];
        case (s)
            S_FETCH:  begin mrd = 1; sb_sel = 2'b01; irw = mr; pcw = mr; end
            S_DECODE: sb_sel = 2'b11;
            S_MEMADR: begin sa = 1; sb_sel = 2'b10; end
            S_MEMRD:  begin iord = 1; mrd = 1; end
            S_MEMWB:  begin rw = 1; m2r = 1; end
            S_MEMWR:  begin iord = 1; mwr = 1; end
            S_EXEC:   begin sa = 1; aop = 2'b10; end
            S_ALUWB:  rw = 1;
            S_BRANCH: begin sa = 1; aop = 2'b01; pcs = 1; pcw = z; end
            default:  ;
        endcase
        if (rst) begin irw = 0; pcw = 0; rw = 0; mwr = 0; end
        r2l = (s != S_FETCH) && ((op == STUR) || (hi == 8'hB4));
        return {iord, mrd, mwr, irw, pcw, pcs, sa, rw, m2r, r2l, sb_sel, aop};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("state", 32'(state_o), 32'(e.st));
            check("ctrl", 32'({IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSrc, ALUSrcA,
                               RegWrite, MemtoReg, Reg2Loc, ALUSrcB, ALUOp}), 32'(e.ctrl));
            check("illegal", 32'(illegal), 32'(e.ill));
            check("count", 32'(instr_count), 32'(e.cnt));
        end
    end

    // One clock cycle: drive inputs, queue what the DUT must show this cycle
    task automatic cyc(input int s, input logic mr, input logic rst);
        exp_t e;
        mem_ready = mr;
        reset     = rst;
        e.st   = 4'(s);
        e.ctrl = exp_ctrl(s, Op, Zero, mr, rst);
        e.ill  = (s == S_DECODE) && !rst && !legal(Op);
        e.cnt  = exp_count;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_instr(input logic [10:0] op, input logic z, input int fw, input int mw);
        logic [7:0] hi;
        Op   = op;
        Zero = z;
        hi   = op[10:3];
        for (int i = 0; i < fw; i++) cyc(S_FETCH, 1'b0, 1'b0);
        cyc(S_FETCH, 1'b1, 1'b0);
        cyc(S_DECODE, rnd(), 1'b0);
        if (op == LDUR) begin
            cyc(S_MEMADR, rnd(), 1'b0);
            for (int i = 0; i < mw; i++) cyc(S_MEMRD, 1'b0, 1'b0);
            cyc(S_MEMRD, 1'b1, 1'b0);
            cyc(S_MEMWB, rnd(), 1'b0);
            exp_count++;
        end else if (op == STUR) begin
            cyc(S_MEMADR, rnd(), 1'b0);
            for (int i = 0; i < mw; i++) cyc(S_MEMWR, 1'b0, 1'b0);
            cyc(S_MEMWR, 1'b1, 1'b0);
            exp_count++;
        end else if (hi == 8'hB4) begin
            cyc(S_BRANCH, rnd(), 1'b0);
            exp_count++;
        end else if (legal(op)) begin
            cyc(S_EXEC, rnd(), 1'b0);
            cyc(S_ALUWB, rnd(), 1'b0);
            exp_count++;
        end
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b0;
        Op        = 11'h000;
        Zero      = 1'b0;
        @(posedge clk);
        #1;
        cyc(S_FETCH, 1'b1, 1'b1);
        cyc(S_FETCH, 1'b1, 1'b1);

        run_instr(LDUR, 1'b0, 0, 0);
        run_instr(STUR, 1'b0, 0, 3);
        run_instr(CBZ, 1'b1, 0, 0);
        run_instr(CBZ, 1'b0, 0, 0);
        run_instr(ADD, 1'b0, 0, 0);
        run_instr(SUB, 1'b1, 0, 0);
        run_instr(AND_, 1'b0, 0, 0);
        run_instr(ORR, 1'b0, 0, 0);
        run_instr(11'h000, 1'b0, 0, 0);
        run_instr(11'h7C1, 1'b1, 1, 0);
        run_instr(LDUR, 1'b1, 2, 2);
        run_instr(11'h5A7, 1'b1, 1, 0);

        // Reset lands while a load waits on memory, with mem_ready rising
        Op   = LDUR;
        Zero = 1'b0;
        cyc(S_FETCH, 1'b1, 1'b0);
        cyc(S_DECODE, 1'b1, 1'b0);
        cyc(S_MEMADR, 1'b0, 1'b0);
        cyc(S_MEMRD, 1'b0, 1'b0);
        cyc(S_MEMRD, 1'b1, 1'b1);
        exp_count = '0;
        cyc(S_FETCH, 1'b1, 1'b1);

        run_instr(STUR, 1'b0, 1, 1);
        run_instr(ADD, 1'b0, 0, 0);
        Op = 11'h000;
        cyc(S_FETCH, 1'b0, 1'b0);

        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
